// File: rtl/fir_sample_sequencer_pkg.sv
// Shared definitions for the FIR sample sequencer: FSM state encodings and
// default widths.
package fir_sample_sequencer_pkg;

    localparam int NB_DATA_DEF  = 21;
    localparam int NB_DEPTH_DEF = 14;
    localparam int NB_DIV_DEF   = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic logic state_is_busy(input logic [2:0] st);
        return (st == ST_CLEAR) || (st == ST_RUN) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/seq_rate_div.sv
// Sample-period down-counter: produces a 1-cycle tick every period+1 enabled
// cycles. Loading arms the counter so the very next enabled cycle ticks.
module seq_rate_div #(
    parameter int NB_DIV = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [NB_DIV-1:0] i_period,
    output logic              o_tick
);

    logic [NB_DIV-1:0] cnt_q;
    logic [NB_DIV-1:0] cnt_d;

    assign o_tick = i_en && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = o_tick ? i_period : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Plays MU/MIC1/MIC2 sample ROMs into fir_adaptive with start/stop, run length,
// sample-rate divider and loop mode; owns the filter reset.
module fir_sample_sequencer
    import fir_sample_sequencer_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NB_DEPTH = NB_DEPTH_DEF,
    parameter int NB_DIV   = NB_DIV_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_loop,
    input  logic [NB_DEPTH-1:0] i_last_addr,
    input  logic [NB_DIV-1:0]   i_div,
    output logic [NB_DEPTH-1:0] o_addr,
    output logic                o_rd_en,
    input  logic [NB_DATA-1:0]  i_mu,
    input  logic [NB_DATA-1:0]  i_mic1,
    input  logic [NB_DATA-1:0]  i_mic2,
    output logic [NB_DATA-1:0]  o_mu,
    output logic [NB_DATA-1:0]  o_mic1,
    output logic [NB_DATA-1:0]  o_mic2,
    output logic                o_valid,
    output logic                o_fir_rst,
    output logic                o_busy,
    output logic                o_done,
    output logic [2:0]          o_state
);

    logic [2:0]          state_q, state_d;
    logic [NB_DEPTH-1:0] addr_q, addr_d;
    logic [NB_DEPTH-1:0] last_q, last_d;
    logic [NB_DIV-1:0]   div_q, div_d;
    logic                loop_q, loop_d;
    logic                pend_q, pend_d;
    logic [NB_DATA-1:0]  mu_q, mu_d;
    logic [NB_DATA-1:0]  mic1_q, mic1_d;
    logic [NB_DATA-1:0]  mic2_q, mic2_d;
    logic                tick;
    logic                rd_en;
    logic                take;

    seq_rate_div #(
        .NB_DIV (NB_DIV)
    ) u_rate_div (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (state_q == ST_RUN),
        .i_load   (state_q == ST_CLEAR),
        .i_period (div_q),
        .o_tick   (tick)
    );

    // Strobe protocol (no backpressure): o_valid is high for exactly one cycle,
    // the cycle after the matching o_rd_en, and o_mu/o_mic1/o_mic2 carry that
    // read's data while it is high and hold it until the next strobe. A stop
    // in the return cycle discards the read: no strobe, outputs keep old data.
    assign rd_en = (state_q == ST_RUN) && tick;
    assign take  = pend_q && !i_stop;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        div_d   = div_q;
        loop_d  = loop_q;
        pend_d  = rd_en && !i_stop;
        mu_d    = mu_q;
        mic1_d  = mic1_q;
        mic2_d  = mic2_q;

        if (take) begin
            mu_d   = i_mu;
            mic1_d = i_mic1;
            mic2_d = i_mic2;
        end

        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (i_start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                last_d  = i_last_addr;
                div_d   = i_div;
                loop_d  = i_loop;
                mu_d    = '0;
                mic1_d  = '0;
                mic2_d  = '0;
                addr_d  = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Compare before incrementing so a last address of all-ones wraps naturally.
                if (tick) begin
                    if (addr_q == last_q) begin
                        if (loop_q) addr_d = '0;
                        else        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_start) state_d = ST_CLEAR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (i_stop) begin
            state_d = ST_IDLE;
            addr_d  = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            div_q   <= '0;
            loop_q  <= 1'b0;
            pend_q  <= 1'b0;
            mu_q    <= '0;
            mic1_q  <= '0;
            mic2_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            div_q   <= div_d;
            loop_q  <= loop_d;
            pend_q  <= pend_d;
            mu_q    <= mu_d;
            mic1_q  <= mic1_d;
            mic2_q  <= mic2_d;
        end
    end

    assign o_addr    = addr_q;
    assign o_rd_en   = rd_en;
    assign o_valid   = take;
    assign o_mu      = take ? i_mu   : mu_q;
    assign o_mic1    = take ? i_mic1 : mic1_q;
    assign o_mic2    = take ? i_mic2 : mic2_q;
    assign o_fir_rst = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
    assign o_busy    = state_is_busy(state_q);
    assign o_done    = (state_q == ST_DONE);
    assign o_state   = state_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: synchronous ROM model, scoreboard of expected
// samples, table of single-pass runs and hand-written corner-case sequences.
module tb_fir_sample_sequencer;

    localparam int NB_DATA  = 21;
    localparam int NB_DEPTH = 14;
    localparam int NB_DIV   = 10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef struct {
        int div;
        int last;
        int exp_reads;
        int exp_done_cyc;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_start = 1'b0;
    logic                i_stop = 1'b0;
    logic                i_loop = 1'b0;
    logic [NB_DEPTH-1:0] i_last_addr = '0;
    logic [NB_DIV-1:0]   i_div = '0;
    logic [NB_DEPTH-1:0] o_addr;
    logic                o_rd_en;
    logic [NB_DATA-1:0]  i_mu = '0;
    logic [NB_DATA-1:0]  i_mic1 = '0;
    logic [NB_DATA-1:0]  i_mic2 = '0;
    logic [NB_DATA-1:0]  o_mu;
    logic [NB_DATA-1:0]  o_mic1;
    logic [NB_DATA-1:0]  o_mic2;
    logic                o_valid;
    logic                o_fir_rst;
    logic                o_busy;
    logic                o_done;
    logic [2:0]          o_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    logic [3*NB_DATA-1:0] exp_q[$];
    int rd_addr_q[$];
    int rd_cyc_q[$];
    int val_cyc_q[$];

    fir_sample_sequencer #(
        .NB_DATA  (NB_DATA),
        .NB_DEPTH (NB_DEPTH),
        .NB_DIV   (NB_DIV)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_loop      (i_loop),
        .i_last_addr (i_last_addr),
        .i_div       (i_div),
        .o_addr      (o_addr),
        .o_rd_en     (o_rd_en),
        .i_mu        (i_mu),
        .i_mic1      (i_mic1),
        .i_mic2      (i_mic2),
        .o_mu        (o_mu),
        .o_mic1      (o_mic1),
        .o_mic2      (o_mic2),
        .o_valid     (o_valid),
        .o_fir_rst   (o_fir_rst),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_state     (o_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- ROM model: data one cycle after the read ----------------
    function automatic logic [3*NB_DATA-1:0] rom_word(input logic [NB_DEPTH-1:0] a);
        logic [NB_DATA-1:0] mu, m1, m2;
        mu = NB_DATA'(a) * 21'd37 + 21'd5;
        m1 = NB_DATA'(a) ^ 21'h155AA;
        m2 = 21'h100000 - NB_DATA'(a);
        return {mu, m1, m2};
    endfunction

    always @(posedge clk) begin
        if (o_rd_en) {i_mu, i_mic1, i_mic2} <= rom_word(o_addr);
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [3*NB_DATA-1:0] e;
        if (!rst) begin
            if (o_rd_en) begin
                rd_addr_q.push_back(int'(o_addr));
                rd_cyc_q.push_back(cyc - t0);
                exp_q.push_back(rom_word(o_addr));
            end
            if (o_valid) begin
                val_cyc_q.push_back(cyc - t0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_unexpected: o_valid at rel cycle %0d with no read pending", cyc - t0);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_data", {1'b0, o_mu, o_mic1, o_mic2}, {1'b0, e});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input int div, input int last, input bit lp);
        @(posedge clk);
        #1;
        i_div       = NB_DIV'(div);
        i_last_addr = NB_DEPTH'(last);
        i_loop      = lp;
        i_start     = 1'b1;
        t0          = cyc;
        rd_addr_q.delete();
        rd_cyc_q.delete();
        val_cyc_q.delete();
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(negedge clk);
        check("clear_state", o_state, S_CLEAR);
        check("clear_fir_rst", o_fir_rst, 1);
        check("clear_busy", o_busy, 1);
        @(negedge clk);
        check("run_fir_rst", o_fir_rst, 0);
        check("first_rd_en", o_rd_en, 1);
        check("first_addr", o_addr, 0);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_done: o_done not seen within %0d cycles", budget);
        end
    endtask

    task automatic check_pass(input int div, input int last, input int exp_reads, input int exp_done);
        int bad;
        logic [3*NB_DATA-1:0] w;
        #1;
        check("done_cycle", cyc - t0, exp_done);
        check("done_busy", o_busy, 0);
        check("done_fir_rst", o_fir_rst, 0);
        check("done_state", o_state, S_DONE);
        check("rd_count", rd_addr_q.size(), exp_reads);
        bad = 0;
        foreach (rd_addr_q[k]) begin
            if (rd_addr_q[k] != k || rd_cyc_q[k] != 2 + k * (div + 1)) bad++;
        end
        check("rd_seq_bad", bad, 0);
        check("valid_count", val_cyc_q.size(), exp_reads);
        bad = 0;
        foreach (val_cyc_q[k]) begin
            if (val_cyc_q[k] != 3 + k * (div + 1)) bad++;
        end
        check("valid_seq_bad", bad, 0);
        check("exp_q_empty", exp_q.size(), 0);
        w = rom_word(NB_DEPTH'(last));
        check("held_samples", {1'b0, o_mu, o_mic1, o_mic2}, {1'b0, w});
        @(negedge clk);
        check("done_hold_no_valid", o_valid, 0);
        check("done_hold_level", o_done, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, o_state, S_IDLE);
        check({tag, "_addr"}, o_addr, 0);
        check({tag, "_rd_en"}, o_rd_en, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_mu"}, o_mu, 0);
        check({tag, "_mic1"}, o_mic1, 0);
        check({tag, "_mic2"}, o_mic2, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_fir_rst"}, o_fir_rst, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs[6];
        bit ok;
        int bad;
        int stop_rel;
        int n_rd;
        logic [3*NB_DATA-1:0] w;

        vecs[0] = '{0, 7, 8, 11};
        vecs[1] = '{3, 2, 3, 12};
        vecs[2] = '{0, 0, 1, 4};
        vecs[3] = '{2, 5, 6, 19};
        vecs[4] = '{1, 3, 4, 10};
        vecs[5] = '{0, 16383, 16384, 16387};

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        #2 rst = 1'b0;

        // Single-pass runs from the table
        foreach (vecs[v]) begin
            do_start(vecs[v].div, vecs[v].last, 1'b0);
            wait_done((vecs[v].last + 1) * (vecs[v].div + 1) + 20, ok);
            if (ok) check_pass(vecs[v].div, vecs[v].last, vecs[v].exp_reads, vecs[v].exp_done_cyc);
        end

        // Loop mode, then stop
        do_start(0, 3, 1'b1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_done || !o_busy) bad++;
        end
        check("loop_never_done", bad, 0);
        @(posedge clk);
        #1;
        i_stop = 1'b1;
        stop_rel = cyc - t0;
        @(negedge clk);
        check("loop_stop_no_valid", o_valid, 0);
        @(posedge clk);
        #1;
        i_stop = 1'b0;
        @(negedge clk);
        check("loop_stop_state", o_state, S_IDLE);
        check("loop_stop_fir_rst", o_fir_rst, 1);
        check("loop_stop_addr", o_addr, 0);
        repeat (3) @(negedge clk);
        #1;
        bad = 0;
        foreach (rd_addr_q[k]) begin
            if (rd_addr_q[k] != k % 4 || rd_cyc_q[k] != 2 + k) bad++;
        end
        check("loop_rd_seq_bad", bad, 0);
        bad = 0;
        foreach (val_cyc_q[k]) begin
            if (val_cyc_q[k] >= stop_rel) bad++;
        end
        check("loop_valid_after_stop", bad, 0);
        n_rd = rd_addr_q.size();
        check("loop_valid_count", val_cyc_q.size(), n_rd - 2);
        exp_q.delete();

        // Stop in the cycle right after a read
        do_start(3, 5, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (rd_addr_q.size() == 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("stop_second_read_seen", ok, 1);
        @(posedge clk);
        #1;
        i_stop = 1'b1;
        @(negedge clk);
        w = rom_word(NB_DEPTH'(0));
        check("stop_inflight_no_valid", o_valid, 0);
        check("stop_hold_samples", {1'b0, o_mu, o_mic1, o_mic2}, {1'b0, w});
        @(posedge clk);
        #1;
        i_stop = 1'b0;
        @(negedge clk);
        check("stop_state", o_state, S_IDLE);
        repeat (4) @(negedge clk);
        #1;
        check("stop_valid_count", val_cyc_q.size(), 1);
        check("stop_hold_after", {1'b0, o_mu, o_mic1, o_mic2}, {1'b0, w});
        exp_q.delete();

        // Start and stop together from IDLE: stop wins
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_stop  = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_stop  = 1'b0;
        @(negedge clk);
        check("startstop_state", o_state, S_IDLE);
        check("startstop_busy", o_busy, 0);
        check("startstop_fir_rst", o_fir_rst, 1);
        @(negedge clk);
        check("startstop_state2", o_state, S_IDLE);

        // Mid-run changes to div/last/loop are ignored
        do_start(1, 4, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        i_div       = NB_DIV'(0);
        i_last_addr = NB_DEPTH'(1);
        i_loop      = 1'b1;
        wait_done(40, ok);
        if (ok) check_pass(1, 4, 5, 12);

        // Restart from DONE
        do_start(0, 2, 1'b0);
        wait_done(20, ok);
        if (ok) check_pass(0, 2, 3, 6);

        // Asynchronous reset mid-run, off-edge
        do_start(2, 9, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        do_start(0, 3, 1'b0);
        wait_done(20, ok);
        if (ok) check_pass(0, 3, 4, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
